// File: rtl/cpu_loader_pkg.sv
// rtl/cpu_loader_pkg.sv - shared states, command codes and error codes for the cpu stream loader
package cpu_loader_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_GET_ADDR, S_GET_LEN, S_GET_BYTE,
    S_A_WAIT, S_A_ASSERT, S_A_RELEASE,
    S_D_WAIT, S_D_ASSERT, S_D_RELEASE,
    S_X_WAIT, S_X_ASSERT,
    S_RUN, S_IN_GET, S_IN_ASSERT, S_IN_RELEASE
  } state_t;

  localparam logic [7:0] DEF_CMD_LOAD = 8'h01;
  localparam logic [7:0] DEF_CMD_RUN  = 8'h02;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_BAD_CMD = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  function automatic logic is_stream_state(state_t s);
    return s inside {S_IDLE, S_GET_ADDR, S_GET_LEN, S_GET_BYTE, S_IN_GET};
  endfunction

  // States where the loader is blocked on the cpu and must not wait forever
  function automatic logic is_watch_state(state_t s);
    return s inside {S_A_WAIT, S_A_ASSERT, S_D_WAIT, S_D_ASSERT, S_D_RELEASE,
                     S_X_WAIT, S_X_ASSERT, S_IN_ASSERT};
  endfunction

endpackage

// File: rtl/handshake_timer.sv
// rtl/handshake_timer.sv - saturating watchdog counter with synchronous clear
module handshake_timer #(
  parameter int TIMEOUT_W = 10
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_saturated
);

  logic [TIMEOUT_W-1:0] count;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count <= '0;
    end else if (i_clear) begin
      count <= '0;
    end else if (i_enable && !o_saturated) begin
      count <= count + 1'b1;
    end
  end

  assign o_saturated = &count;

endmodule

// File: rtl/cpu_stream_loader.sv
// rtl/cpu_stream_loader.sv - byte stream to cpu level-handshake loader and runner
module cpu_stream_loader
  import cpu_loader_pkg::*;
#(
  parameter int         TIMEOUT_W = 10,
  parameter logic [7:0] CMD_LOAD  = DEF_CMD_LOAD,
  parameter logic [7:0] CMD_RUN   = DEF_CMD_RUN
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  output logic       o_rx_ready,
  output logic       o_cpu_load_addr,
  output logic       o_cpu_load_data,
  output logic       o_cpu_execute,
  output logic       o_cpu_input_taken,
  output logic [7:0] o_cpu_data,
  input  logic       i_cpu_waiting,
  input  logic       i_cpu_take_input,
  output logic       o_busy,
  output logic       o_running,
  output logic       o_halted,
  output logic       o_error,
  output logic [1:0] o_err_code
);

  state_t     state, state_nxt;
  logic [7:0] addr_q, addr_nxt, byte_q, byte_nxt, data_nxt;
  logic [8:0] count_q, count_nxt;
  logic [1:0] code_nxt;
  logic       err_nxt, halt_nxt;
  logic       rx_take, wd_sat, wd_clear;
  logic       cpu_idle, cpu_dphase, cpu_inreq;

  assign rx_take    = i_rx_valid & o_rx_ready;
  assign cpu_idle   = i_cpu_waiting & ~i_cpu_take_input;
  assign cpu_dphase = ~i_cpu_waiting & i_cpu_take_input;
  assign cpu_inreq  = i_cpu_waiting & i_cpu_take_input;
  assign wd_clear   = (state_nxt != state) || !is_watch_state(state);

  handshake_timer #(.TIMEOUT_W(TIMEOUT_W)) u_timer (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_clear     (wd_clear),
    .i_enable    (is_watch_state(state)),
    .o_saturated (wd_sat)
  );

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    count_nxt = count_q;
    byte_nxt  = byte_q;
    data_nxt  = o_cpu_data;
    code_nxt  = o_err_code;
    err_nxt   = 1'b0;
    halt_nxt  = 1'b0;
    case (state)
      S_IDLE: if (rx_take) begin
        if (i_rx_data == CMD_LOAD)     state_nxt = S_GET_ADDR;
        else if (i_rx_data == CMD_RUN) state_nxt = S_X_WAIT;
        else begin
          err_nxt  = 1'b1;
          code_nxt = ERR_BAD_CMD;
        end
      end
      S_GET_ADDR: if (rx_take) begin
        addr_nxt  = i_rx_data;
        state_nxt = S_GET_LEN;
      end
      // A length byte of zero encodes a full 256-byte block
      S_GET_LEN: if (rx_take) begin
        count_nxt = (i_rx_data == 8'd0) ? 9'd256 : {1'b0, i_rx_data};
        state_nxt = S_GET_BYTE;
      end
      S_GET_BYTE: if (rx_take) begin
        byte_nxt  = i_rx_data;
        data_nxt  = addr_q;
        state_nxt = S_A_WAIT;
      end
      S_A_WAIT:    if (cpu_idle)        state_nxt = S_A_ASSERT;
      S_A_ASSERT:  if (!i_cpu_waiting)  state_nxt = S_A_RELEASE;
      S_A_RELEASE: begin
        data_nxt  = byte_q;
        state_nxt = S_D_WAIT;
      end
      S_D_WAIT:    if (cpu_dphase)        state_nxt = S_D_ASSERT;
      S_D_ASSERT:  if (!i_cpu_take_input) state_nxt = S_D_RELEASE;
      S_D_RELEASE: if (cpu_idle) begin
        addr_nxt  = addr_q + 8'd1;
        count_nxt = count_q - 9'd1;
        state_nxt = (count_q == 9'd1) ? S_IDLE : S_GET_BYTE;
      end
      S_X_WAIT:   if (cpu_idle)       state_nxt = S_X_ASSERT;
      S_X_ASSERT: if (!i_cpu_waiting) state_nxt = S_RUN;
      S_RUN: begin
        if (cpu_inreq) state_nxt = S_IN_GET;
        else if (cpu_idle) begin
          halt_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_IN_GET: if (rx_take) begin
        data_nxt  = i_rx_data;
        state_nxt = S_IN_ASSERT;
      end
      S_IN_ASSERT:  if (!i_cpu_waiting) state_nxt = S_IN_RELEASE;
      S_IN_RELEASE: state_nxt = S_RUN;
      default:      state_nxt = S_IDLE;
    endcase
    if (is_watch_state(state) && wd_sat) begin
      state_nxt = S_IDLE;
      err_nxt   = 1'b1;
      code_nxt  = ERR_TIMEOUT;
    end
  end

  // Outputs are decoded from the next state so every strobe is a clean register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state             <= S_IDLE;
      addr_q            <= '0;
      count_q           <= '0;
      byte_q            <= '0;
      o_cpu_data        <= '0;
      o_err_code        <= ERR_NONE;
      o_error           <= 1'b0;
      o_halted          <= 1'b0;
      o_rx_ready        <= 1'b0;
      o_cpu_load_addr   <= 1'b0;
      o_cpu_load_data   <= 1'b0;
      o_cpu_execute     <= 1'b0;
      o_cpu_input_taken <= 1'b0;
      o_busy            <= 1'b0;
      o_running         <= 1'b0;
    end else begin
      state             <= state_nxt;
      addr_q            <= addr_nxt;
      count_q           <= count_nxt;
      byte_q            <= byte_nxt;
      o_cpu_data        <= data_nxt;
      o_err_code        <= code_nxt;
      o_error           <= err_nxt;
      o_halted          <= halt_nxt;
      o_rx_ready        <= is_stream_state(state_nxt);
      o_cpu_load_addr   <= (state_nxt == S_A_ASSERT);
      o_cpu_load_data   <= (state_nxt == S_D_ASSERT);
      o_cpu_execute     <= (state_nxt == S_X_ASSERT);
      o_cpu_input_taken <= (state_nxt == S_IN_ASSERT);
      o_busy            <= (state_nxt != S_IDLE);
      o_running         <= state_nxt inside {S_RUN, S_IN_GET, S_IN_ASSERT, S_IN_RELEASE};
    end
  end

endmodule

// File: tb/tb_cpu_stream_loader.sv
// tb/tb_cpu_stream_loader.sv - scoreboard bench for cpu_stream_loader against a cpu handshake model
module tb_cpu_stream_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready, ld_addr, ld_data, execute, in_taken;
  logic [7:0] cpu_data;
  logic       cpu_waiting = 1'b1;
  logic       cpu_take = 1'b0;
  logic       busy, running, halted, error;
  logic [1:0] err_code;

  always #5 clk = ~clk;

  cpu_stream_loader dut (
    .i_clk             (clk),
    .i_reset_n         (rst_n),
    .i_rx_data         (rx_data),
    .i_rx_valid        (rx_valid),
    .o_rx_ready        (rx_ready),
    .o_cpu_load_addr   (ld_addr),
    .o_cpu_load_data   (ld_data),
    .o_cpu_execute     (execute),
    .o_cpu_input_taken (in_taken),
    .o_cpu_data        (cpu_data),
    .i_cpu_waiting     (cpu_waiting),
    .i_cpu_take_input  (cpu_take),
    .o_busy            (busy),
    .o_running         (running),
    .o_halted          (halted),
    .o_error           (error),
    .o_err_code        (err_code)
  );

  typedef struct {
    logic       is_input;
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   writes = 0;
  int   halts = 0;
  int   excl_viol = 0;
  bit   saw_running = 0;
  bit   stuck = 0;
  bit   prog_wrim = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cpu model: idle = waiting&!take, data phase = !waiting&take, input request = both
  typedef enum int {M_IDLE, M_ADDR, M_DATA, M_DREL, M_EXEC, M_RUN, M_REQ, M_TREL} m_t;
  m_t         m = M_IDLE;
  logic [7:0] m_addr = 8'h00;
  int         dly = 0;
  bit         wrim_left = 0;

  always @(negedge clk) begin : cpu_model
    exp_t e;
    if (stuck) begin
      cpu_waiting <= 1'b1;
      cpu_take    <= 1'b0;
      m           <= M_IDLE;
    end else begin
      case (m)
        M_IDLE: begin
          cpu_waiting <= 1'b1;
          cpu_take    <= 1'b0;
          if (ld_addr) begin
            m_addr      <= cpu_data;
            cpu_waiting <= 1'b0;
            m           <= M_ADDR;
          end else if (execute) begin
            cpu_waiting <= 1'b0;
            wrim_left   <= prog_wrim;
            m           <= M_EXEC;
          end
        end
        M_ADDR: if (!ld_addr) begin
          cpu_take <= 1'b1;
          m        <= M_DATA;
        end
        M_DATA: if (ld_data) begin
          writes <= writes + 1;
          check_eq("write_expected", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check_eq("wr_kind", e.is_input, 0);
            check_eq("wr_addr", m_addr, e.addr);
            check_eq("wr_data", cpu_data, e.data);
          end
          cpu_take <= 1'b0;
          m        <= M_DREL;
        end
        M_DREL: if (!ld_data) begin
          cpu_waiting <= 1'b1;
          m           <= M_IDLE;
        end
        M_EXEC: if (!execute) begin
          dly <= 5;
          m   <= M_RUN;
        end
        M_RUN: begin
          if (dly > 0) dly <= dly - 1;
          else if (wrim_left) begin
            cpu_waiting <= 1'b1;
            cpu_take    <= 1'b1;
            m           <= M_REQ;
          end else begin
            cpu_waiting <= 1'b1;
            m           <= M_IDLE;
          end
        end
        M_REQ: if (in_taken) begin
          check_eq("input_expected", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check_eq("in_kind", e.is_input, 1);
            check_eq("in_data", cpu_data, e.data);
          end
          wrim_left   <= 1'b0;
          cpu_waiting <= 1'b0;
          cpu_take    <= 1'b0;
          m           <= M_TREL;
        end
        M_TREL: if (!in_taken) begin
          dly <= 5;
          m   <= M_RUN;
        end
        default: m <= M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin : monitor
    if ($countones({ld_addr, ld_data, execute, in_taken}) > 1) excl_viol <= excl_viol + 1;
    if (halted) halts <= halts + 1;
    if (running) saw_running <= 1'b1;
  end

  task automatic send_byte(input logic [7:0] b, input int bound);
    bit ok = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int n = 0; n < bound; n++) begin
      if (rx_ready) begin
        @(posedge clk);
        @(negedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    rx_valid = 1'b0;
    check_eq("byte_consumed", ok, 1);
  endtask

  task automatic wait_idle(input string tag);
    for (int n = 0; n < 500 && busy; n++) @(negedge clk);
    check_eq(tag, busy, 0);
  endtask

  task automatic load_block(input logic [7:0] addr, input int n, input logic [7:0] d0, input bit rnd);
    logic [7:0] d;
    int w0 = writes;
    send_byte(8'h01, 50);
    send_byte(addr, 50);
    send_byte(n[7:0], 50);
    for (int i = 0; i < n; i++) begin
      d = rnd ? 8'($urandom_range(0, 255)) : 8'(d0 + 8'h11 * i);
      sb.push_back('{is_input: 1'b0, addr: 8'(addr + i), data: d});
      send_byte(d, 200);
    end
    wait_idle("load_idle");
    check_eq("load_writes", writes - w0, n);
    check_eq("load_sb_empty", sb.size(), 0);
  endtask

  logic [18:0] all_out;
  assign all_out = {rx_ready, ld_addr, ld_data, execute, in_taken, cpu_data,
                    busy, running, halted, error, err_code};

  initial begin
    int cnt;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", all_out, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_rx_ready", rx_ready, 1);
    check_eq("idle_busy", busy, 0);

    load_block(8'h10, 3, 8'hAA, 0);
    load_block(8'hFE, 3, 8'h11, 0);
    load_block(8'h00, 256, 8'h00, 1);

    prog_wrim = 1;
    send_byte(8'h02, 50);
    sb.push_back('{is_input: 1'b1, addr: 8'h00, data: 8'h5A});
    send_byte(8'h5A, 2000);
    wait_idle("run_idle");
    @(negedge clk);
    check_eq("run_halts", halts, 1);
    check_eq("run_saw_running", saw_running, 1);
    check_eq("run_running_low", running, 0);
    check_eq("run_sb_empty", sb.size(), 0);

    send_byte(8'h07, 50);
    check_eq("bad_error", error, 1);
    check_eq("bad_code", err_code, 2'b01);
    check_eq("bad_busy", busy, 0);
    @(negedge clk);
    check_eq("bad_pulse_end", error, 0);

    stuck = 1;
    prog_wrim = 0;
    send_byte(8'h02, 50);
    for (int n = 0; n < 20 && !execute; n++) @(negedge clk);
    check_eq("to_execute_seen", execute, 1);
    cnt = 1;
    for (int n = 0; n < 1200; n++) begin
      @(negedge clk);
      if (error) break;
      if (execute) cnt++;
    end
    check_eq("to_error", error, 1);
    check_eq("to_length", (cnt >= 1023 && cnt <= 1025), 1);
    check_eq("to_code", err_code, 2'b10);
    check_eq("to_execute_low", execute, 0);
    check_eq("to_busy", busy, 0);

    send_byte(8'h01, 50);
    send_byte(8'h20, 50);
    send_byte(8'h01, 50);
    send_byte(8'h77, 50);
    for (int n = 0; n < 20 && !ld_addr; n++) @(negedge clk);
    check_eq("rst_ld_addr_seen", ld_addr, 1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_ld_addr_drop", ld_addr, 0);
    check_eq("rst_mid_outputs", all_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst_release_outputs", all_out, 0);
    @(negedge clk);
    check_eq("rst_rx_ready", rx_ready, 1);
    check_eq("rst_busy", busy, 0);
    stuck = 0;

    check_eq("halts_total", halts, 1);
    check_eq("strobe_exclusive", excl_viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
